tag_demux_fifo: RTL and testbench

Downstream companion of the parametric SDF accumulator. It accepts the tagged token stream that the accumulator writes on out0_wr/out0_data/out0_full. Each token is {tag, payload}, with the tag in the MSBs. The block strips the tag and buffers the payload in one of FLUX independent circular FIFOs, one per flux. Each flux is then exposed as an ordinary empty/read FIFO port, so per-flux consumer actors can attach directly.

---
 rtl/tag_demux_fifo.sv | 88 ++++++++
 tb/tb_tag_demux_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tag_demux_fifo.sv
// Tag demultiplexer: strips the tag from each incoming token and buffers the
// payload in one of FLUX circular FIFOs exposed as first-word-fall-through ports.
module tag_demux_fifo #(
  parameter int unsigned FLUX  = 2,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                                    ck,
  input  logic                                    rst,
  input  logic                                    in_wr,
  input  logic [WIDTH-1:0]                        in_data,
  output logic                                    in_full,
  output logic [(WIDTH-$clog2(FLUX))*FLUX-1:0]    out_data,
  output logic [FLUX-1:0]                         out_empty,
  input  logic [FLUX-1:0]                         out_read,
  output logic [1:0]                              err
);

  localparam int unsigned TAG_WIDTH = $clog2(FLUX);
  localparam int unsigned PW        = WIDTH - TAG_WIDTH;
  localparam int unsigned AW        = $clog2(DEPTH);

  logic [PW-1:0]        mem    [FLUX][DEPTH];
  logic [AW:0]          wr_ptr [FLUX];
  logic [AW:0]          rd_ptr [FLUX];
  logic [FLUX-1:0]      full;
  logic [TAG_WIDTH-1:0] tag;
  logic [PW-1:0]        payload;
  logic                 bad_tag;
  logic                 wr_en;

  assign tag     = in_data[WIDTH-1 -: TAG_WIDTH];
  assign payload = in_data[PW-1:0];
  // Only reachable when FLUX is not a power of two.
  assign bad_tag = {1'b0, tag} >= (TAG_WIDTH+1)'(FLUX);
  assign wr_en   = in_wr && !in_full && !bad_tag;
  assign in_full = |full;

  // Status and FWFT heads, decoded from registered pointers only.
  always_comb begin
    full      = '0;
    out_empty = '0;
    out_data  = '0;
    for (int unsigned f = 0; f < FLUX; f++) begin
      out_empty[f] = (wr_ptr[f] == rd_ptr[f]);
      full[f]      = (wr_ptr[f][AW-1:0] == rd_ptr[f][AW-1:0]) &&
                     (wr_ptr[f][AW] != rd_ptr[f][AW]);
      out_data[f*PW +: PW] = mem[f][rd_ptr[f][AW-1:0]];
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int unsigned f = 0; f < FLUX; f++) begin
        wr_ptr[f] <= '0;
        rd_ptr[f] <= '0;
      end
    end else begin
      for (int unsigned f = 0; f < FLUX; f++) begin
        if (wr_en && (tag == TAG_WIDTH'(f)))
          wr_ptr[f] <= wr_ptr[f] + (AW+1)'(1);
        if (out_read[f] && !out_empty[f])
          rd_ptr[f] <= rd_ptr[f] + (AW+1)'(1);
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge ck) begin
    for (int unsigned f = 0; f < FLUX; f++) begin
      if (wr_en && (tag == TAG_WIDTH'(f)))
        mem[f][wr_ptr[f][AW-1:0]] <= payload;
    end
  end

  // Sticky error flags; overflow takes priority over a bad tag.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      err <= '0;
    end else if (in_wr) begin
      if (in_full)
        err[1] <= 1'b1;
      else if (bad_tag)
        err[0] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tag_demux_fifo.sv
// Directed bench for tag_demux_fifo: stimulus pushes expected heads into
// per-flux queues, a negedge monitor pops and compares them on every read.
module tb_tag_demux_fifo;

  logic        ck;
  logic        rst;
  logic        in_wr;
  logic [7:0]  in_data;
  logic        in_full;
  logic [13:0] out_data;
  logic [1:0]  out_empty;
  logic [1:0]  out_read;
  logic [1:0]  err;

  logic        in_wr3;
  logic [7:0]  in_data3;
  logic        in_full3;
  logic [17:0] out_data3;
  logic [2:0]  out_empty3;
  logic [2:0]  out_read3;
  logic [1:0]  err3;

  int vectors;
  int miscompares;

  logic [6:0] exp_q0[$];
  logic [6:0] exp_q1[$];

  tag_demux_fifo #(.FLUX(2), .WIDTH(8), .DEPTH(4)) dut (
    .ck(ck), .rst(rst), .in_wr(in_wr), .in_data(in_data), .in_full(in_full),
    .out_data(out_data), .out_empty(out_empty), .out_read(out_read), .err(err)
  );

  tag_demux_fifo #(.FLUX(3), .WIDTH(8), .DEPTH(4)) dut3 (
    .ck(ck), .rst(rst), .in_wr(in_wr3), .in_data(in_data3), .in_full(in_full3),
    .out_data(out_data3), .out_empty(out_empty3), .out_read(out_read3), .err(err3)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: a read strobe seen mid-cycle consumes the head the bench expects.
  task automatic mon_flux(input int f);
    logic [6:0] exp;
    logic       emp;
    logic [6:0] head;
    emp  = out_empty[f];
    head = (f == 0) ? out_data[6:0] : out_data[13:7];
    if ((f == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0)) begin
      exp = (f == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("head_f%0d", f), {24'd0, emp, head}, {24'd0, 1'b0, exp});
    end else begin
      check($sformatf("empty_on_read_f%0d", f), {31'd0, emp}, 32'd1);
    end
  endtask

  always @(negedge ck) begin
    if (!rst) begin
      if (out_read[0]) mon_flux(0);
      if (out_read[1]) mon_flux(1);
    end
  end

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic write(input logic [7:0] d, input bit expect_accept);
    in_wr   = 1'b1;
    in_data = d;
    if (expect_accept) begin
      if (d[7]) exp_q1.push_back(d[6:0]);
      else      exp_q0.push_back(d[6:0]);
    end
    step();
    in_wr = 1'b0;
  endtask

  task automatic read(input logic [1:0] m);
    out_read = m;
    step();
    out_read = '0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; in_wr = 1'b0; in_data = '0; out_read = '0;
    in_wr3 = 1'b0; in_data3 = '0; out_read3 = '0;
    #3;
    check("reset_empty", {30'd0, out_empty}, 32'h3);
    check("reset_full", {31'd0, in_full}, 32'h0);
    check("reset_err", {30'd0, err}, 32'h0);
    step();
    rst = 1'b0;
    step();

    // Read on empty after reset: monitor expects empty on both fluxes.
    read(2'b11);
    check("rd_empty_empty", {30'd0, out_empty}, 32'h3);
    check("rd_empty_err", {30'd0, err}, 32'h0);

    // Routing by tag.
    write(8'h05, 1'b1);
    write(8'h85, 1'b1);
    check("route_empty", {30'd0, out_empty}, 32'h0);
    check("route_err", {30'd0, err}, 32'h0);
    check("route_f0", {25'd0, out_data[6:0]}, 32'h05);
    check("route_f1", {25'd0, out_data[13:7]}, 32'h05);
    read(2'b11);
    check("route_drained", {30'd0, out_empty}, 32'h3);

    // Fill, overflow and drain three times to wrap the pointers.
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= 4; i++) begin
        write(8'(r * 16 + i), 1'b1);
        check("fill_full", {31'd0, in_full}, (i == 4) ? 32'd1 : 32'd0);
      end
      write(8'h0F, 1'b0);
      check("overflow_err", {30'd0, err}, 32'h2);
      for (int i = 0; i < 4; i++) read(2'b01);
      check("drain_empty0", {31'd0, out_empty[0]}, 32'd1);
      check("drain_full", {31'd0, in_full}, 32'd0);
    end

    // A write in the same cycle a read frees the full flux is still dropped.
    for (int i = 1; i <= 4; i++) write(8'(8'h30 + i), 1'b1);
    in_wr = 1'b1; in_data = 8'h36; out_read = 2'b01;
    step();
    in_wr = 1'b0; out_read = '0;
    check("free_cycle_full", {31'd0, in_full}, 32'd0);
    for (int i = 0; i < 3; i++) read(2'b01);
    check("free_cycle_dropped", {31'd0, out_empty[0]}, 32'd1);

    // Simultaneous write and read on flux1 holding one entry.
    write(8'h91, 1'b1);
    exp_q1.push_back(7'h12);
    in_wr = 1'b1; in_data = 8'h92; out_read = 2'b10;
    step();
    in_wr = 1'b0; out_read = '0;
    check("simul_nonempty", {31'd0, out_empty[1]}, 32'd0);
    check("simul_head", {25'd0, out_data[13:7]}, 32'h12);
    read(2'b10);
    check("simul_occ1", {31'd0, out_empty[1]}, 32'd1);

    // Asynchronous reset in the middle of traffic.
    write(8'h07, 1'b1);
    write(8'h83, 1'b1);
    #2 rst = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    #1;
    check("mid_rst_empty", {30'd0, out_empty}, 32'h3);
    check("mid_rst_full", {31'd0, in_full}, 32'h0);
    check("mid_rst_err", {30'd0, err}, 32'h0);
    step();
    step();
    check("mid_rst_hold_empty", {30'd0, out_empty}, 32'h3);
    check("mid_rst_hold_err", {30'd0, err}, 32'h0);
    rst = 1'b0;
    step();
    write(8'h15, 1'b1);
    read(2'b01);
    check("post_rst_empty", {30'd0, out_empty}, 32'h3);

    // Bad tag on the three-flux instance.
    in_wr3 = 1'b1; in_data3 = 8'hC7;
    step();
    in_wr3 = 1'b0;
    check("bad_tag_err", {30'd0, err3}, 32'h1);
    check("bad_tag_empty", {29'd0, out_empty3}, 32'h7);
    in_wr3 = 1'b1; in_data3 = 8'h87;
    step();
    in_wr3 = 1'b0;
    check("tag2_empty", {29'd0, out_empty3}, 32'h3);
    check("tag2_head", {26'd0, out_data3[17:12]}, 32'h07);
    check("tag2_err", {30'd0, err3}, 32'h1);
    out_read3 = 3'b100;
    step();
    out_read3 = '0;
    check("tag2_drained", {29'd0, out_empty3}, 32'h7);

    step();
    check("queues_consumed", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
